// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipe_reg_chain slice.
//   - Legal ranges for the STAGES and WIDTH parameters.
//   - occ_width(): bit width needed to count 0..stages valid stages.
// ----------------------------------------------------------------------------
package pipe_pkg;

    localparam int unsigned STAGES_MIN = 32'd1;
    localparam int unsigned STAGES_MAX = 32'd8;
    localparam int unsigned WIDTH_MIN  = 32'd1;
    localparam int unsigned WIDTH_MAX  = 32'd64;

    // Width of a counter able to hold every value 0..stages. Never returns
    // zero, so that a bad parameter still yields a legal port declaration and
    // the dedicated range check reports the real problem.
    function automatic int unsigned occ_width(input int unsigned stages);
        int unsigned w;
        w = $clog2(stages + 32'd1);
        if (w == 32'd0) begin
            return 32'd1;
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// ----------------------------------------------------------------------------
// pipe_stage
// One elastic register stage: a valid bit plus a WIDTH-bit data register.
// The stage is ready when it is empty or when its downstream neighbour is
// ready, so an occupied stage can load while its word moves on. A flush
// clears the valid bit but deliberately leaves the data register alone.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high; clears valid and data
//   flush      : synchronous discard of the held word
//   up_valid   : upstream valid (in_valid for stage 0, else previous stage)
//   up_data    : upstream payload
//   down_ready : readiness of the next stage (out_ready for the last stage)
//   ready      : this stage accepts up_data on the coming edge
//   valid      : registered valid bit
//   valid_nxt  : value valid will take on the coming edge
//   data       : registered payload
// ----------------------------------------------------------------------------
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32'd8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             down_ready,
    output logic             ready,
    output logic             valid,
    output logic             valid_nxt,
    output logic [WIDTH-1:0] data
);

    logic             valid_r;
    logic [WIDTH-1:0] data_r;
    logic             ready_s;
    logic             valid_nxt_s;
    logic [WIDTH-1:0] data_nxt_s;

    assign ready_s   = ~valid_r | down_ready;
    assign ready     = ready_s;
    assign valid     = valid_r;
    assign valid_nxt = valid_nxt_s;
    assign data      = data_r;

    // Next-state selection: flush wins, then load when ready, else hold.
    always_comb begin
        valid_nxt_s = valid_r;
        data_nxt_s  = data_r;
        if (flush) begin
            valid_nxt_s = 1'b0;
            data_nxt_s  = data_r;
        end else if (ready_s) begin
            valid_nxt_s = up_valid;
            data_nxt_s  = up_data;
        end else begin
            valid_nxt_s = valid_r;
            data_nxt_s  = data_r;
        end
    end

    // Stage registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= 1'b0;
            data_r  <= {WIDTH{1'b0}};
        end else begin
            valid_r <= valid_nxt_s;
            data_r  <= data_nxt_s;
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// ----------------------------------------------------------------------------
// pipe_reg_chain
// A chain of STAGES elastic register stages with valid/ready handshakes on
// both ends. Bubbles are squeezed out under back-pressure, a full chain can
// accept and deliver in the same cycle, and flush empties the chain in one
// cycle. out_valid/out_data come straight from the last stage's registers.
//
// Parameters
//   WIDTH  : payload bits, 1..64
//   STAGES : number of register stages, 1..8
//
// Ports
//   clk       : clock, rising edge
//   reset     : asynchronous, active-high; empties the chain and zeroes data
//   flush     : synchronous discard of all held words
//   in_valid  : upstream presents in_data
//   in_ready  : chain accepts in_data this cycle
//   in_data   : payload in
//   out_valid : last stage holds a valid word
//   out_ready : downstream accepts out_data
//   out_data  : payload of the last stage
//   occupancy : number of stages currently holding a valid word
// ----------------------------------------------------------------------------
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = 32'd8,
    parameter int unsigned STAGES = 32'd3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [occ_width(STAGES)-1:0]   occupancy
);

    localparam int unsigned OCC_W = occ_width(STAGES);

    // Parameter range checks, reported at elaboration.
    if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_bad_width
        $error("pipe_reg_chain: WIDTH %0d outside legal range 1..64", WIDTH);
    end
    if ((STAGES < STAGES_MIN) || (STAGES > STAGES_MAX)) begin : g_bad_stages
        $error("pipe_reg_chain: STAGES %0d outside legal range 1..8", STAGES);
    end

    logic             up_valid_s   [STAGES];
    logic [WIDTH-1:0] up_data_s    [STAGES];
    logic             down_ready_s [STAGES];
    logic             ready_s      [STAGES];
    logic             valid_s      [STAGES];
    logic             valid_nxt_s  [STAGES];
    logic [WIDTH-1:0] data_s       [STAGES];

    logic [OCC_W-1:0] occ_nxt_s;
    logic [OCC_W-1:0] occ_r;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        // Stage 0 takes the input port; later stages take their predecessor.
        if (i == 0) begin : g_first
            assign up_valid_s[i] = in_valid;
            assign up_data_s[i]  = in_data;
        end else begin : g_mid
            assign up_valid_s[i] = valid_s[i-1];
            assign up_data_s[i]  = data_s[i-1];
        end

        // The last stage sees the output handshake; others see their successor.
        if (i == STAGES - 1) begin : g_last
            assign down_ready_s[i] = out_ready;
        end else begin : g_inner
            assign down_ready_s[i] = ready_s[i+1];
        end

        pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush),
            .up_valid   (up_valid_s[i]),
            .up_data    (up_data_s[i]),
            .down_ready (down_ready_s[i]),
            .ready      (ready_s[i]),
            .valid      (valid_s[i]),
            .valid_nxt  (valid_nxt_s[i]),
            .data       (data_s[i])
        );
    end

    // Population count of the valid bits the stages will hold after the edge.
    always_comb begin
        occ_nxt_s = {OCC_W{1'b0}};
        for (int unsigned k = 0; k < STAGES; k++) begin
            occ_nxt_s = occ_nxt_s + OCC_W'(valid_nxt_s[k]);
        end
    end

    // Occupancy register, kept in step with the stage valid bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_r <= {OCC_W{1'b0}};
        end else begin
            occ_r <= occ_nxt_s;
        end
    end

    // Reset is folded in because an empty chain would otherwise look ready.
    assign in_ready  = ready_s[0] & ~flush & ~reset;
    assign out_valid = valid_s[STAGES-1];
    assign out_data  = data_s[STAGES-1];
    assign occupancy = occ_r;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// ----------------------------------------------------------------------------
// tb_pipe_reg_chain
// Self-checking bench for pipe_reg_chain (WIDTH=8, STAGES=3). The reference
// model is a queue of in-flight words, each with a position along the chain;
// words advance one place per cycle unless caught up behind the word ahead.
// ----------------------------------------------------------------------------
module tb_pipe_reg_chain;

    localparam int S = 3;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    int checks = 0;
    int errors = 0;
    int accepted = 0;
    int delivered = 0;

    typedef struct {
        logic [W-1:0] data;
        int           pos;
    } word_t;
    word_t q[$];

    typedef struct {
        logic         iv;
        logic [W-1:0] din;
        logic         ordy;
        logic         fl;
        logic         e_ir;
        logic         e_ov;
        logic [W-1:0] e_dat;
        logic [1:0]   e_occ;
    } vec_t;
    vec_t vecs[16];

    pipe_reg_chain #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Compare the DUT against the model for this cycle, then advance the model
    // across the coming clock edge. Called between negedge and posedge.
    task automatic model_cycle();
        bit exp_ir;
        bit exp_ov;
        bit in_x;
        bit out_x;
        int cap;
        int np;
        exp_ir = !flush && ((q.size() < S) || out_ready);
        exp_ov = (q.size() > 0) && (q[0].pos == S - 1);
        chk("m_in_ready", in_ready, exp_ir);
        chk("m_out_valid", out_valid, exp_ov);
        chk("m_occupancy", occupancy, q.size());
        if (exp_ov) chk("m_out_data", out_data, q[0].data);
        in_x  = in_valid && exp_ir;
        out_x = exp_ov && out_ready;
        if (out_x) begin
            void'(q.pop_front());
            delivered++;
        end
        if (flush) begin
            q.delete();
        end else begin
            for (int k = 0; k < q.size(); k++) begin
                cap = (k == 0) ? (S - 1) : (q[k-1].pos - 1);
                np  = q[k].pos + 1;
                q[k].pos = (np < cap) ? np : cap;
            end
            if (in_x) begin
                q.push_back('{data: in_data, pos: 0});
                accepted++;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        // Streaming: three back-to-back words, out_ready held high.
        vecs[0]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
        vecs[1]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1};
        vecs[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd2};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 2'd3};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 2'd2};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 2'd1};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
        // Fill under back-pressure, fourth word refused, then drain.
        vecs[7]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
        vecs[8]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1};
        vecs[9]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd2};
        vecs[10] = '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd3};
        vecs[11] = '{1'b1, 8'hA4, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA1, 2'd3};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA2, 2'd3};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA3, 2'd2};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA4, 2'd1};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};

        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_occupancy", occupancy, 2'd0);
        chk("rst_in_ready", in_ready, 1'b0);
        reset = 1'b0;

        // Table-driven streaming and fill/drain.
        for (int r = 0; r < 16; r++) begin
            drive(vecs[r].iv, vecs[r].din, vecs[r].ordy, vecs[r].fl);
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", r), in_ready, vecs[r].e_ir);
            chk($sformatf("vec%0d_out_valid", r), out_valid, vecs[r].e_ov);
            chk($sformatf("vec%0d_occupancy", r), occupancy, vecs[r].e_occ);
            if (vecs[r].e_ov) chk($sformatf("vec%0d_out_data", r), out_data, vecs[r].e_dat);
            model_cycle();
            @(posedge clk);
            #1;
        end

        // Stall stability: 0xA5 parked at the output for five cycles.
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_out_valid", out_valid, 1'b1);
            chk("stall_out_data", out_data, 8'hA5);
            chk("stall_occupancy", occupancy, 2'd1);
            model_cycle();
            @(posedge clk);
            #1;
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        step();

        // Flush with two words held and a new word offered.
        drive(1'b1, 8'hB1, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'hB2, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'h7E, 1'b0, 1'b1);
        @(negedge clk);
        chk("flush_in_ready", in_ready, 1'b0);
        chk("flush_occ_before", occupancy, 2'd2);
        model_cycle();
        @(posedge clk);
        #1;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        chk("flush_occ_after", occupancy, 2'd0);
        chk("flush_out_valid", out_valid, 1'b0);
        model_cycle();
        @(posedge clk);
        #1;
        repeat (5) step();

        // Asynchronous reset between edges with a full chain.
        drive(1'b1, 8'hC1, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'hC2, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'hC3, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_reset_occupancy", occupancy, 2'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("async_out_valid", out_valid, 1'b0);
        chk("async_out_data", out_data, 8'h00);
        chk("async_occupancy", occupancy, 2'd0);
        chk("async_in_ready", in_ready, 1'b0);
        #1;
        reset = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        drive(1'b1, 8'hC4, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        step();
        @(negedge clk);
        chk("post_reset_latency_valid", out_valid, 1'b1);
        chk("post_reset_latency_data", out_data, 8'hC4);
        model_cycle();
        @(posedge clk);
        #1;
        step();

        // Random traffic against the model.
        accepted = 0;
        delivered = 0;
        for (int cyc = 0; (cyc < 20000) && (accepted < 1000); cyc++) begin
            drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 8'($urandom),
                  ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, 1'b0);
            @(negedge clk);
            chk("rand_occ_bound", (occupancy <= 2'd3) ? 1'b1 : 1'b0, 1'b1);
            model_cycle();
            @(posedge clk);
            #1;
        end
        chk("rand_accepted", accepted, 1000);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        for (int c = 0; (c < 20) && (q.size() > 0); c++) step();
        step();
        chk("rand_delivered", delivered, accepted);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_reg_chain.md
PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per stage, legal 1..64.
REQ-002 SHALL have parameter STAGES, default 3: number of register stages, legal 1..8.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port flush, input, 1 bit: synchronous discard of all held data.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream presents in_data.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-008 SHALL have port in_data, input, WIDTH bits: payload in.
REQ-009 SHALL have port out_valid, output, 1 bit: last stage holds valid payload.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-011 SHALL have port out_data, output, WIDTH bits: payload from last stage.
REQ-012 SHALL have port occupancy, output, $clog2(STAGES+1) bits: count of stages with valid set.

Function
REQ-013 Stage i SHALL hold a valid bit v[i] and a WIDTH-bit data register d[i]; stage 0 is fed by the input, stage STAGES-1 drives out_valid/out_data.
REQ-014 A transfer SHALL occur at a port on any cycle where its valid and ready are both 1; no other condition transfers data.
REQ-015 Stage i SHALL be ready when v[i]=0 or stage i+1 is ready; the last stage SHALL be ready when v[last]=0 or out_ready=1.
REQ-016 in_ready SHALL equal stage-0 readiness AND NOT flush.
REQ-017 A stage that is ready SHALL load its upstream data and valid on the clock edge; a stage that is not ready SHALL hold d[i] and v[i] unchanged.
REQ-018 Latency SHALL be exactly STAGES cycles from input transfer to out_valid=1 when out_ready is held 1.
REQ-019 Throughput SHALL be one transfer per cycle when out_ready is held 1 with no bubbles inserted.
REQ-020 Once out_valid=1, out_valid and out_data SHALL stay stable until an output transfer occurs.
REQ-021 Order SHALL be preserved: words leave in the order accepted; no word is duplicated or dropped except by flush or reset.
REQ-022 Back-pressure SHALL compress bubbles: with out_ready=0, accepted words fill stages toward the output until all STAGES are valid, then in_ready=0.
REQ-023 When all stages are valid and out_ready=1, in_ready SHALL be 1 (simultaneous enter and leave on a full chain).
REQ-024 flush=1 SHALL clear every v[i] on the next edge, override any transfer, and leave d[i] unchanged; an output transfer during the flush cycle still counts as delivered.
REQ-025 occupancy SHALL equal the population count of v[] registered state, range 0..STAGES.
REQ-026 out_data SHALL be d[STAGES-1] directly (registered, no combinational path from in_data).

Reset
REQ-027 Assertion of reset SHALL immediately clear all v[i] and d[i] to 0, independent of clk, including mid-transfer.
REQ-028 During reset: out_valid=0, out_data=0, occupancy=0, in_ready=0.
REQ-029 First transfer after reset deassertion SHALL be possible on the first rising clk edge with reset low.

Structure
REQ-030 A shared package pipe_pkg SHALL hold the STAGES legal limits and an occupancy-width helper function.
REQ-031 A sub-module pipe_stage (one valid bit plus WIDTH-bit register, ready-in/ready-out) SHALL be instantiated STAGES times by a generate loop.
REQ-032 Illegal WIDTH or STAGES SHALL cause an elaboration-time error.

Verification
REQ-033 Streaming: STAGES=3, out_ready=1, inputs 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 on cycles 3,4,5, out_valid continuous.
REQ-034 Fill: out_ready=0, 4 words offered -> 3 accepted, in_ready=0 on 4th, occupancy=3; out_ready=1 -> words drained in order, in_ready=1 same cycle.
REQ-035 Stall stability: out_valid=1 with out_data=0xA5, out_ready=0 for 5 cycles -> out_data held 0xA5, occupancy unchanged.
REQ-036 Flush: occupancy=2, flush=1 with in_valid=1 data 0x7E -> in_ready=0, next cycle occupancy=0, out_valid=0, 0x7E never appears.
REQ-037 Async reset: reset pulsed between edges with occupancy=3 -> outputs 0 before next edge; next accepted word emerges after STAGES cycles.
REQ-038 Random back-pressure: 1000 random words, random in_valid/out_ready -> scoreboard matches exactly, occupancy never exceeds STAGES.
